wta_winner_decoder: RTL

Downstream consumer of the winner-take-all network's per-neuron spike vector. Counts spikes per neuron over a fixed observation window, then picks the neuron with the highest count. Publishes the winner index and count, and drives a 7-segment pattern onto the dedicated output pins of the top level.

---
 rtl/wta_pkg.sv | 28 ++
 rtl/wta_spike_counter.sv | 27 ++
 rtl/wta_winner_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/wta_pkg.sv
// rtl/wta_pkg.sv - shared types and constants for the WTA winner decoder
//
// Contents:
//   wta_state_t  - decoder FSM states (IDLE, COUNT, COMPARE, PUBLISH)
//   SEG_DIGIT    - 7-segment glyphs {dp,g,f,e,d,c,b,a} for digits 0..7
//   SEG_DASH     - 7-segment dash glyph (segment g only)
//   idx_w()      - width of a neuron index for a given neuron count
package wta_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        COMPARE = 2'd2,
        PUBLISH = 2'd3
    } wta_state_t;

    localparam logic [7:0] SEG_DIGIT [8] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07
    };

    localparam logic [7:0] SEG_DASH = 8'h40;

    // At least one bit so a 1-neuron-wide index is still a legal vector.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wta_spike_counter.sv
// rtl/wta_spike_counter.sv - one saturating per-neuron spike counter
//
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   clear  - synchronous clear to zero (priority over inc)
//   inc    - add one this cycle unless already at full scale
//   count  - current count, sticks at 2^CNT_W-1
module wta_spike_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wta_winner_decoder.sv
// rtl/wta_winner_decoder.sv - windowed spike counting and winner selection
//
// Counts spikes per neuron over WINDOW cycles, scans the counts one neuron
// per cycle for the maximum (lowest index wins ties), then publishes the
// result for one cycle and starts the next window if enable is still high.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   enable        - run windows; when low the current window still finishes
//   spikes_in     - one spike bit per neuron, counted only in COUNT
//   winner_idx    - index of the last published winner
//   winner_count  - spike count of the last published winner
//   winner_valid  - one-cycle pulse per published result
//   no_spike      - last window saw no spikes at all
//   tie           - last winner shared its count with another neuron
//   seg_out       - 7-segment / status pattern {dp,g,f,e,d,c,b,a}
//
// Build option WTA_SEG_DECODE_EN: seg_out shows the winner digit glyph with
// dp = tie (dash when silent or in reset); otherwise seg_out is the status
// word {tie, no_spike, winner_valid_sticky, winner_idx zero-extended}.
module wta_winner_decoder
    import wta_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int CNT_W     = 8,
    parameter int WINDOW    = 200
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [N_NEURONS-1:0]         spikes_in,
    output logic [$clog2(N_NEURONS)-1:0] winner_idx,
    output logic [CNT_W-1:0]             winner_count,
    output logic                         winner_valid,
    output logic                         no_spike,
    output logic                         tie,
    output logic [7:0]                   seg_out
);

    localparam int IDX_W = idx_w(N_NEURONS);

    wta_state_t       state;
    wta_state_t       state_next;
    logic [15:0]      win_cnt;
    logic [IDX_W-1:0] cmp_idx;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] cnt [N_NEURONS];
    logic [CNT_W-1:0] cur_cnt;
    logic             clear_cnt;
    logic             window_done;
    logic             scan_done;
    logic             tie_c;
    logic             no_spike_c;

    assign window_done = (win_cnt == 16'(WINDOW - 1));
    assign scan_done   = (cmp_idx == IDX_W'(N_NEURONS - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = COUNT;
            COUNT:   if (window_done) state_next = COMPARE;
            COMPARE: if (scan_done) state_next = PUBLISH;
            PUBLISH: state_next = enable ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters restart from zero on every entry into a counting window.
    assign clear_cnt = (state_next == COUNT) && (state != COUNT);

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cnt
        wta_spike_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_cnt),
            .inc   (spikes_in[g] && (state == COUNT)),
            .count (cnt[g])
        );
    end

    // Loop mux avoids indexing past N_NEURONS when it is not a power of two.
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (cmp_idx == IDX_W'(i)) cur_cnt = cnt[i];
        end
    end

    // Evaluated in PUBLISH once the scan has settled on the final maximum.
    always_comb begin
        no_spike_c = (best_cnt == '0);
        tie_c      = 1'b0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if ((IDX_W'(i) != best_idx) && (cnt[i] == best_cnt)) tie_c = 1'b1;
        end
        if (no_spike_c) tie_c = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            win_cnt      <= '0;
            cmp_idx      <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            winner_idx   <= '0;
            winner_count <= '0;
            winner_valid <= 1'b0;
            no_spike     <= 1'b0;
            tie          <= 1'b0;
        end else begin
            state        <= state_next;
            winner_valid <= 1'b0;
            case (state)
                COUNT: begin
                    win_cnt <= window_done ? 16'd0 : win_cnt + 16'd1;
                    if (window_done) begin
                        cmp_idx  <= '0;
                        best_idx <= '0;
                        best_cnt <= '0;
                    end
                end
                COMPARE: begin
                    if (cur_cnt > best_cnt) begin
                        best_cnt <= cur_cnt;
                        best_idx <= cmp_idx;
                    end
                    cmp_idx <= cmp_idx + 1'b1;
                end
                PUBLISH: begin
                    winner_idx   <= best_idx;
                    winner_count <= best_cnt;
                    tie          <= tie_c;
                    no_spike     <= no_spike_c;
                    winner_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef WTA_SEG_DECODE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out <= SEG_DASH;
        end else if (state == PUBLISH) begin
            seg_out <= no_spike_c ? SEG_DASH : {tie_c, SEG_DIGIT[best_idx][6:0]};
        end
    end
`else
    logic winner_valid_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            winner_valid_sticky <= 1'b0;
        end else if (state == PUBLISH) begin
            winner_valid_sticky <= 1'b1;
        end
    end

    assign seg_out = {tie, no_spike, winner_valid_sticky, 5'(winner_idx)};
`endif

endmodule
